// File: rtl/mips_mem_arbiter.sv
// Shares a single-ported memory between instruction fetch and data ports of a MIPS pipeline.
// Optional macro ARB_FAIRNESS_EN bounds the data streak a waiting fetch will tolerate.
module mips_mem_arbiter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DSTREAK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_adr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_adr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_adr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ready,
  output logic                  stall
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  owner_data_q, owner_data_d;
  logic                  m_req_q, m_req_d;
  logic                  m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0] m_adr_q, m_adr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_ack_q, i_ack_d;
  logic                  d_ack_q, d_ack_d;

  logic d_any;
  logic fetch_due;
  logic grant_data;
  logic grant_fetch;

  assign d_any = d_read | d_write;

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned StreakW = (DSTREAK_MAX > 0) ? $clog2(DSTREAK_MAX + 1) : 1;

  logic [StreakW-1:0] streak_q, streak_d;

  // A fetch that has watched DSTREAK_MAX data grants go by wins the next slot.
  assign fetch_due = i_req && (streak_q == StreakW'(DSTREAK_MAX));

  always_comb begin
    streak_d = streak_q;
    if (grant_fetch) begin
      streak_d = '0;
    end else if (grant_data) begin
      if (!i_req) begin
        streak_d = '0;
      end else if (streak_q != StreakW'(DSTREAK_MAX)) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign fetch_due = 1'b0;
`endif

  assign grant_data  = (state_q == StIdle) && d_any && !fetch_due;
  assign grant_fetch = (state_q == StIdle) && i_req && (!d_any || fetch_due);

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_adr_d      = m_adr_q;
    m_wdata_d    = m_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          // A simultaneous read and write is serviced as the write alone.
          owner_data_d = 1'b1;
          m_req_d      = 1'b1;
          m_we_d       = d_write;
          m_adr_d      = d_adr;
          m_wdata_d    = d_wdata;
          state_d      = StAccess;
        end else if (grant_fetch) begin
          owner_data_d = 1'b0;
          m_req_d      = 1'b1;
          m_we_d       = 1'b0;
          m_adr_d      = i_adr;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (m_ready) begin
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          state_d = StResp;
          if (owner_data_q) begin
            d_ack_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_rdata;
          end
        end
      end
      StResp: begin
        // No arbitration here, so the just-acked request is not re-granted.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_data_q <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_adr_q      <= '0;
      m_wdata_q    <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_adr_q      <= m_adr_d;
      m_wdata_q    <= m_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_adr   = m_adr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign stall   = (i_req & ~i_ack_q) | (d_any & ~d_ack_q);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios plus randomized transactions
// scored against a transaction-level timing/memory model.
module tb_mips_mem_arbiter;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int DSTREAK = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_read, d_write;
  logic [AW-1:0] i_adr, d_adr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_ack, d_ack;
  logic          m_req, m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_ready;
  logic          stall;

  always #5 clk = ~clk;

  mips_mem_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DSTREAK_MAX(DSTREAK)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_req  (i_req),
    .i_adr  (i_adr),
    .i_rdata(i_rdata),
    .i_ack  (i_ack),
    .d_read (d_read),
    .d_write(d_write),
    .d_adr  (d_adr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ack  (d_ack),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_adr  (m_adr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ready(m_ready),
    .stall  (stall)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] mem     [16];  // memory device contents
  logic [31:0] ref_mem [16];  // expected contents
  int          lat_q[$];
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] exp_irdata = '0;
  logic [31:0] exp_drdata = '0;

  // Memory device: answers each access after the next queued number of wait cycles.
  task automatic mem_step();
    if (m_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      end
      if (mem_cnt == 0) begin
        m_ready = 1'b1;
        m_rdata = mem[m_adr[5:2]];
        if (m_we) mem[m_adr[5:2]] = m_wdata;
        mem_cnt = -1;
      end else begin
        m_ready = 1'b0;
        m_rdata = $urandom;
        if (mem_cnt > 0) mem_cnt--;
      end
    end else begin
      mem_busy = 1'b0;
      m_ready  = 1'($urandom_range(0, 1));
      m_rdata  = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_step();
  endtask

  // Presents one set of requests in IDLE and scores every cycle until all are acked.
  task automatic run_txn(input bit f, input bit r, input bit w, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] wd, input int lat_d,
                         input int lat_f, input string tag);
    bit          has_d;
    int          n0, g_d, a_d, g_f, a_f, last;
    logic [31:0] val_d, val_f;
    bit          in_d, in_f;
    has_d = r | w;
    n0    = cyc;
    g_d = -100; a_d = -100; g_f = -100; a_f = -100;
    val_d = '0; val_f = '0;
    if (has_d) begin
      g_d = n0 + 1;
      a_d = g_d + 1 + lat_d;
      lat_q.push_back(lat_d);
      if (w) ref_mem[da[5:2]] = wd;
      else val_d = ref_mem[da[5:2]];
    end
    if (f) begin
      g_f = has_d ? a_d + 2 : n0 + 1;
      a_f = g_f + 1 + lat_f;
      lat_q.push_back(lat_f);
      val_f = ref_mem[ia[5:2]];
    end
    last = f ? a_f : a_d;
    i_req = f; i_adr = ia; d_read = r; d_write = w; d_adr = da; d_wdata = wd;
    while (cyc <= last) begin
      tick();
      in_d = (cyc >= g_d) && (cyc < a_d);
      in_f = (cyc >= g_f) && (cyc < a_f);
      if (cyc == a_d && r && !w) exp_drdata = val_d;
      if (cyc == a_f) exp_irdata = val_f;
      n_checks += 6;
      if (m_req !== (in_d || in_f)) begin
        n_fail++;
        $display("FAIL %s m_req cyc=%0d got=%b exp=%b", tag, cyc, m_req, in_d || in_f);
      end
      if (i_ack !== (cyc == a_f)) begin
        n_fail++;
        $display("FAIL %s i_ack cyc=%0d got=%b exp=%b", tag, cyc, i_ack, cyc == a_f);
      end
      if (d_ack !== (cyc == a_d)) begin
        n_fail++;
        $display("FAIL %s d_ack cyc=%0d got=%b exp=%b", tag, cyc, d_ack, cyc == a_d);
      end
      if (stall !== ((i_req && cyc != a_f) || ((d_read || d_write) && cyc != a_d))) begin
        n_fail++;
        $display("FAIL %s stall cyc=%0d got=%b", tag, cyc, stall);
      end
      if (i_rdata !== exp_irdata) begin
        n_fail++;
        $display("FAIL %s i_rdata cyc=%0d got=%h exp=%h", tag, cyc, i_rdata, exp_irdata);
      end
      if (d_rdata !== exp_drdata) begin
        n_fail++;
        $display("FAIL %s d_rdata cyc=%0d got=%h exp=%h", tag, cyc, d_rdata, exp_drdata);
      end
      if (in_d || in_f) begin
        n_checks += 2;
        if (m_adr !== (in_d ? da : ia)) begin
          n_fail++;
          $display("FAIL %s m_adr cyc=%0d got=%h exp=%h", tag, cyc, m_adr, in_d ? da : ia);
        end
        if (m_we !== (in_d && w)) begin
          n_fail++;
          $display("FAIL %s m_we cyc=%0d got=%b exp=%b", tag, cyc, m_we, in_d && w);
        end
        if (in_d && w) begin
          n_checks++;
          if (m_wdata !== wd) begin
            n_fail++;
            $display("FAIL %s m_wdata cyc=%0d got=%h exp=%h", tag, cyc, m_wdata, wd);
          end
        end
      end
      if (cyc == a_d) begin d_read = 1'b0; d_write = 1'b0; end
      if (cyc == a_f) i_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_req = 0; d_read = 0; d_write = 0; i_adr = '0; d_adr = '0; d_wdata = '0;
    m_ready = 0; m_rdata = '0;
    tick(); tick();
    n_checks++;
    if ({m_req, m_we, i_ack, d_ack, stall} !== 5'b0 || m_adr !== '0 || m_wdata !== '0 ||
        i_rdata !== '0 || d_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_state got req=%b we=%b iack=%b dack=%b adr=%h wd=%h ird=%h drd=%h exp=all zero",
               m_req, m_we, i_ack, d_ack, m_adr, m_wdata, i_rdata, d_rdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_read();
    run_txn(1, 0, 0, 32'h40, '0, '0, 0, 0, "fetch_read");
    n_checks++;
    if (i_rdata !== 32'h2000_0000) begin
      n_fail++;
      $display("FAIL fetch_read_data got=%h exp=20000000", i_rdata);
    end
  endtask

  task automatic test_store_load();
    run_txn(0, 0, 1, '0, 32'h10, 32'hA5, 0, 0, "store");
    run_txn(0, 1, 0, '0, 32'h10, '0, 0, 0, "load");
    n_checks++;
    if (d_rdata !== 32'hA5) begin
      n_fail++;
      $display("FAIL store_load_data got=%h exp=000000a5", d_rdata);
    end
  endtask

  task automatic test_collision();
    run_txn(1, 1, 0, 32'h3C, 32'h08, '0, 0, 0, "collision");
  endtask

  task automatic test_slow_memory();
    run_txn(1, 1, 0, 32'h24, 32'h18, '0, 5, 5, "slow_memory");
  endtask

  task automatic test_read_write_both();
    run_txn(0, 1, 1, '0, 32'h2C, 32'h1234_5678, 1, 0, "read_write_both");
  endtask

  task automatic test_reset_mid_access();
    i_req = 1'b1; i_adr = 32'h20;
    lat_q.push_back(20);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({m_req, m_we, i_ack, d_ack} !== 4'b0 || m_adr !== '0 || i_rdata !== '0 ||
        d_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_access got req=%b we=%b iack=%b dack=%b adr=%h exp=all zero",
               m_req, m_we, i_ack, d_ack, m_adr);
    end
    i_req = 1'b0;
    exp_irdata = '0;
    exp_drdata = '0;
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (i_ack !== 1'b0 || d_ack !== 1'b0 || m_req !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_ack cyc=%0d got iack=%b dack=%b req=%b exp=0", cyc, i_ack, d_ack,
                 m_req);
      end
    end
    run_txn(1, 0, 0, 32'h20, '0, '0, 1, 0, "after_reset");
  endtask

  task automatic test_fairness();
    localparam int G = 10;
    int  k;
    bit  prev, done, is_f, exp_f;
    i_req = 1'b1; i_adr = 32'h3C; d_read = 1'b1; d_write = 1'b0; d_adr = 32'h04;
    k = 0; prev = 1'b0; done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      tick();
      if (m_req && !prev) begin
`ifdef ARB_FAIRNESS_EN
        exp_f = (k >= G) || ((k % (DSTREAK + 1)) == DSTREAK);
`else
        exp_f = (k >= G);
`endif
        is_f = (m_adr == 32'h3C);
        n_checks++;
        if (is_f !== exp_f) begin
          n_fail++;
          $display("FAIL fairness grant=%0d fetch got=%b exp=%b", k, is_f, exp_f);
        end
        k++;
      end
      prev = m_req;
      if ((i_ack || d_ack) && k == G) d_read = 1'b0;
      if (i_ack && k == G + 1) begin
        i_req = 1'b0;
        done  = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL fairness_timeout got grants=%0d exp=%0d", k, G + 1);
      i_req = 1'b0; d_read = 1'b0;
    end
    tick();
    exp_irdata = ref_mem[15];
    exp_drdata = ref_mem[1];
  endtask

  task automatic test_random();
    int          p, idle;
    bit          f, r, w;
    logic [31:0] ia, da, wd;
    for (int it = 0; it < 30; it++) begin
      p  = $urandom_range(0, 5);
      f  = (p == 0) || (p >= 4);
      r  = (p == 1) || (p == 3) || (p == 4);
      w  = (p == 2) || (p == 3) || (p == 5);
      ia = 32'($urandom_range(0, 15)) << 2;
      da = 32'($urandom_range(0, 15)) << 2;
      wd = $urandom;
      run_txn(f, r, w, ia, da, wd, $urandom_range(0, 3), $urandom_range(0, 3), "random");
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0]     = 32'h2000_0000;
    ref_mem[0] = 32'h2000_0000;
    test_reset();
    test_fetch_read();
    test_store_load();
    test_collision();
    test_slow_memory();
    test_read_write_both();
    test_reset_mid_access();
    test_fairness();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Arbitrates requests and sequences a variable-latency memory access with a ready handshake.
- Returns read data and a one-cycle acknowledge to the winning port.
- Drives a stall to the pipeline while any request is outstanding.

Parameters:
- DATA_WIDTH, 32, width of read/write data on all ports.
- ADDR_WIDTH, 32, width of all addresses.
- DSTREAK_MAX, 4, consecutive data grants tolerated while fetch waits (used only with ARB_FAIRNESS_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch read request; level, held with i_adr stable until i_ack.
- i_adr  in  ADDR_WIDTH  fetch address.
- i_rdata  out  DATA_WIDTH  fetch read data; registered, valid in i_ack cycle, held until next fetch ack.
- i_ack  out  1  one-cycle fetch completion pulse.
- d_read  in  1  data read request (lb); level, held until d_ack.
- d_write  in  1  data write request (sb); level, held until d_ack.
- d_adr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_rdata  out  DATA_WIDTH  load data; registered, valid in d_ack cycle of a read, held otherwise.
- d_ack  out  1  one-cycle data completion pulse.
- m_req  out  1  memory access strobe.
- m_we  out  1  memory write enable, qualified by m_req.
- m_adr  out  ADDR_WIDTH  memory address.
- m_wdata  out  DATA_WIDTH  memory write data.
- m_rdata  in  DATA_WIDTH  memory read data, valid when m_ready=1.
- m_ready  in  1  memory completes the current access in this cycle.
- stall  out  1  pipeline freeze request.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - m_req, m_we, i_ack, d_ack = 0.
  - m_adr, m_wdata, i_rdata, d_rdata = 0.
  - streak counter = 0.
  - Reset mid-access abandons the access; no ack is issued.
- FSM states IDLE, ACCESS, RESP.
- IDLE:
  - If d_read or d_write is high, grant data.
  - Else if i_req is high, grant fetch.
  - On grant, register m_adr, m_wdata and m_we (m_we = d_write for data, 0 for fetch), set m_req=1, go to ACCESS.
  - No request: remain in IDLE.
- ACCESS:
  - m_req, m_we, m_adr and m_wdata are held stable.
  - When m_ready=1: drop m_req/m_we and go to RESP.
  - On a read, capture m_rdata into the winner's rdata register.
  - Assert the winner's ack (registered) for the RESP cycle only.
  - While m_ready=0: stay in ACCESS indefinitely.
- RESP: ack high for one cycle, then unconditionally go to IDLE. Arbitration never occurs in RESP, so the acked requester's still-high request is not re-granted.
- Latency: with m_ready tied high, ack appears 2 cycles after request is sampled in IDLE. Back-to-back accesses occupy 3 cycles each.
- d_read and d_write both high: treated as a write; read ignored. d_rdata is unchanged.
- Write completion: d_ack pulses; d_rdata keeps its previous value.
- stall = (i_req & ~i_ack) | ((d_read|d_write) & ~d_ack), combinational.
- Requests withdrawn while in IDLE are simply not granted. Withdrawal during ACCESS is illegal; the access still completes and acks.
- m_ready outside ACCESS is ignored.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - The streak counter increments on each data grant made while i_req=1.
  - When the counter equals DSTREAK_MAX in IDLE and i_req=1, fetch is granted even if data is requesting.
  - The counter clears on any fetch grant, or on a data grant with i_req=0.
  - The counter saturates at DSTREAK_MAX.
- Undefined: fixed data-over-fetch priority; no counter logic is synthesised.

Test Plan:
- Fetch read: i_req=1, i_adr=0x40, m_ready=1, m_rdata=0x20000000 → m_req high 1 cycle with m_adr=0x40, m_we=0; i_ack pulses 2 cycles after request; i_rdata=0x20000000; stall low after ack.
- Store then load: d_write=1, d_adr=0x10, d_wdata=0xA5 → m_we=1, m_wdata=0xA5, d_ack pulse, d_rdata unchanged. Then d_read=1, d_adr=0x10, m_rdata=0xA5 → d_rdata=0xA5.
- Collision: i_req and d_read both high in IDLE → data granted first (m_adr=d_adr). Fetch granted in IDLE after RESP, 3 cycles later. Both acks seen once each.
- Slow memory: m_ready low 5 cycles during ACCESS → m_req, m_adr and stall held for all 5 cycles; ack exactly 1 cycle after the m_ready cycle.
- Reset mid-access: assert reset during ACCESS → m_req=0 immediately, no ack, outputs zero, FSM in IDLE. A new request after release completes normally.
- ARB_FAIRNESS_EN defined, DSTREAK_MAX=4: i_req held, data requests continuous → exactly 4 data grants, then 1 fetch grant, then data resumes. Without the macro, fetch is never granted until data stops.
